// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : 4-digit multiplexed 7-segment driver with double-buffered
//                    value, leading-zero blanking and brightness window.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int          NUM_DIGITS  = 4,
  parameter logic [15:0] REFRESH_DIV = 16'd2500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [2:0]              brightness,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam logic [1:0]  LAST_IDX  = 2'(NUM_DIGITS - 1);
  localparam logic [15:0] SLOT_LAST = REFRESH_DIV - 16'd1;

  logic [15:0]              div_cnt_q, div_cnt_d;
  logic [1:0]               idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]  active_q, active_d;
  logic                     pending_q, pending_d;
  logic [6:0]               segments_q, segments_d;
  logic [NUM_DIGITS-1:0]    digit_en_q, digit_en_d;
  logic                     frame_done_q, frame_done_d;

  logic                     slot_tick;
  logic                     frame_wrap;
  logic [18:0]              on_prod;
  logic [18:0]              on_limit;
  logic                     on_window;
  logic [3:0]               nibble;
  logic                     blank_digit;
  logic [6:0]               pattern;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  assign slot_tick  = (div_cnt_q == SLOT_LAST);
  assign frame_wrap = slot_tick && (idx_q == LAST_IDX);

  // Full 19-bit product keeps (brightness+1)*REFRESH_DIV exact before the shift.
  assign on_prod   = (19'(brightness) + 19'd1) * 19'(REFRESH_DIV);
  assign on_limit  = on_prod >> 3;
  assign on_window = (19'(div_cnt_q) < on_limit);

  assign nibble      = active_q[{idx_q, 2'b00} +: 4];
  assign blank_digit = blank_lz && (idx_q != 2'd0) &&
                       ((active_q >> {idx_q, 2'b00}) == '0);
  assign pattern     = blank_digit ? 7'h00 : seg_decode(nibble);

  always_comb begin
    div_cnt_d    = slot_tick ? 16'd0 : div_cnt_q + 16'd1;
    idx_d        = idx_q;
    if (slot_tick) begin
      idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end

    // Frame swap consumes the pre-load shadow; a coincident load re-arms pending.
    active_d  = active_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    digit_en_d   = on_window ? (NUM_DIGITS'(1) << idx_q) : '0;
    segments_d   = on_window ? pattern : 7'h00;
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      segments_q   <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      segments_q   <= segments_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : randomized bench with a slot/frame arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg7_scan_driver;

  localparam logic [15:0] RD = 16'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .brightness(brightness),
    .segments  (segments),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: cycle count since reset release plus the display buffers.
  int          m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_shadow  = 16'h0;
    m_active  = 16'h0;
    m_pending = 1'b0;
  endtask

  // One clock: drive inputs, predict the registered outputs, compare, advance model.
  task automatic step(input logic ld, input logic [15:0] val);
    int          pos, dig, lim;
    logic        wrap, on, blank;
    logic [3:0]  nib;
    logic [3:0]  exp_en;
    logic [6:0]  exp_seg;
    @(negedge clk);
    load  = ld;
    value = val;
    pos   = m_t % int'(RD);
    dig   = (m_t / int'(RD)) % 4;
    wrap  = (pos == int'(RD) - 1) && (dig == 3);
    lim   = ((int'(brightness) + 1) * int'(RD)) / 8;
    on    = (pos < lim);
    nib   = 4'((m_active >> (4 * dig)) & 16'hF);
    blank = blank_lz && (dig > 0) && ((m_active >> (4 * dig)) == 16'h0);
    exp_en  = on ? 4'(1 << dig) : 4'h0;
    exp_seg = (on && !blank) ? font[nib] : 7'h00;
    @(posedge clk);
    #1;
    check("digit_en", 32'(digit_en), 32'(exp_en));
    check("segments", 32'(segments), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(wrap));
    if (wrap && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_shadow  = val;
      m_pending = 1'b1;
    end
    m_t++;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0);
  endtask

  // Advance until the state about to be clocked sits at frame phase ph (0..31).
  task automatic run_to_phase(input int ph);
    for (int k = 0; k < 64 && (m_t % 32) != ph; k++) step(1'b0, 16'h0);
  endtask

  initial begin
    model_reset();
    #23;
    check("rst_segments", 32'(segments), 32'h0);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Basic scan from reset release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 16'h0);
    check("first_digit_en", 32'(digit_en), 32'h1);
    check("first_segments", 32'(segments), 32'h3F);
    run(70);

    // Mid-frame load, then a load coincident with the frame wrap.
    run_to_phase(13);
    step(1'b1, 16'h1234);
    run(70);
    run_to_phase(31);
    step(1'b1, 16'h00A5);
    run(70);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    step(1'b1, 16'h0070);
    run(70);
    step(1'b1, 16'h0000);
    run(70);

    // Brightness windows.
    brightness = 3'd0;
    run(40);
    brightness = 3'd3;
    run(40);
    brightness = 3'd7;
    blank_lz   = 1'b0;

    // Asynchronous reset while digit 2 is being shown.
    step(1'b1, 16'h1234);
    run(40);
    run_to_phase(2 * 8 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_segments", 32'(segments), 32'h0);
    check("async_digit_en", 32'(digit_en), 32'h0);
    check("async_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 16'h0);
    check("restart_digit_en", 32'(digit_en), 32'h1);
    check("restart_segments", 32'(segments), 32'h3F);
    run(40);

    // Randomized traffic.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 99) < 4) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 4) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 2))
          0:       step(1'b1, 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)));
          default: step(1'b1, 16'($urandom));
        endcase
      end else begin
        step(1'b0, 16'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
